// File: rtl/dcache_tag_lookup.sv
// dcache_tag_lookup
// Tag, valid, dirty and tree-PLRU storage for a set-associative data cache,
// with a two-cycle lookup/update pipeline and a flush/writeback engine.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_*               lookup request (valid/ready handshake, accepted in IDLE)
//                       req_mode: 00 tagcheck read, 01 tagcheck write,
//                                 10 no-tagcheck read of req_way, 11 fill
//   update_metadata     allow the PLRU tree to be touched by this request
//   resp_*              one-cycle response, valid the cycle after acceptance;
//                       valid/dirty arrays and resp_tag/resp_dirty show the set
//                       before the update, resp_plru shows it after
//   flush_start/type    start a flush (0 invalidate, 1 clean, 2/3 clean+invalidate)
//   flush_busy/done     flush in progress / one-cycle completion pulse
//   wb_*                writeback offer of a dirty line, held until wb_ready
module dcache_tag_lookup #(
  parameter int NUM_SETS = 64,
  parameter int WAYS     = 4,
  parameter int TAG_SIZE = 18,
  localparam int IDX_W   = $clog2(NUM_SETS),
  localparam int WAY_W   = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IDX_W-1:0]    req_index,
  input  logic [TAG_SIZE-1:0] req_tag,
  input  logic [1:0]          req_mode,
  input  logic [WAY_W-1:0]    req_way,
  input  logic                update_metadata,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic [WAY_W-1:0]    resp_way,
  output logic [TAG_SIZE-1:0] resp_tag,
  output logic                resp_dirty,
  output logic [WAY_W-1:0]    resp_victim_way,
  output logic [WAYS-1:0]     resp_valid_array,
  output logic [WAYS-1:0]     resp_dirty_array,
  output logic [WAYS-2:0]     resp_plru,
  input  logic                flush_start,
  input  logic [1:0]          flush_type,
  output logic                flush_busy,
  output logic                flush_done,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [IDX_W-1:0]    wb_index,
  output logic [WAY_W-1:0]    wb_way,
  output logic [TAG_SIZE-1:0] wb_tag
);

  typedef enum logic [1:0] {IDLE, RESP, FLUSH_SCAN, FLUSH_WB} state_t;

  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

  // Index of the lowest set bit (0 when none is set).
  function automatic logic [WAY_W-1:0] lowestSet(input logic [WAYS-1:0] v);
    logic [WAY_W-1:0] r;
    r = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (v[w]) r = WAY_W'(w);
    end
    return r;
  endfunction

  // The PLRU tree is heap-ordered: node 0 is the root, children of node n are
  // 2n+1 (left, lower ways) and 2n+2 (right). A node bit of 0 points left.
  // The tree is padded to WAYS bits so node numbers fit in WAY_W bits.
  function automatic logic [WAY_W-1:0] plruVictim(input logic [WAYS-2:0] bits);
    logic [WAYS-1:0]  tree;
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] way;
    logic             d;
    tree = {1'b0, bits};
    node = '0;
    way  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      d                  = tree[node];
      way[WAY_W - 1 - l] = d;
      node               = (node << 1) + WAY_W'(1) + WAY_W'(d);
    end
    return way;
  endfunction

  // Make every node on the path to way w point to the other subtree.
  function automatic logic [WAYS-2:0] plruTouch(input logic [WAYS-2:0] bits,
                                                input logic [WAY_W-1:0] w);
    logic [WAYS-1:0]  tree;
    logic [WAY_W-1:0] node;
    logic             d;
    tree = {1'b0, bits};
    node = '0;
    for (int l = 0; l < WAY_W; l++) begin
      d          = w[WAY_W - 1 - l];
      tree[node] = ~d;
      node       = (node << 1) + WAY_W'(1) + WAY_W'(d);
    end
    return tree[WAYS-2:0];
  endfunction

  // Storage arrays
  logic [TAG_SIZE-1:0] tag_q   [NUM_SETS][WAYS];
  logic [WAYS-1:0]     valid_q [NUM_SETS];
  logic [WAYS-1:0]     dirty_q [NUM_SETS];
  logic [WAYS-2:0]     plru_q  [NUM_SETS];

  // Control registers
  state_t              state_q, state_d;
  logic [IDX_W-1:0]    reqIdx_q, reqIdx_d;
  logic [TAG_SIZE-1:0] reqTag_q, reqTag_d;
  logic [1:0]          reqMode_q, reqMode_d;
  logic [WAY_W-1:0]    reqWay_q, reqWay_d;
  logic                reqUpd_q, reqUpd_d;
  logic [1:0]          flushType_q, flushType_d;
  logic [IDX_W-1:0]    scanSet_q, scanSet_d;
  logic [WAY_W-1:0]    scanWay_q, scanWay_d;
  logic                done_q, done_d;

  // Lookup datapath signals
  logic                inResp;
  logic [WAYS-1:0]     setValid, setDirty, hitVec;
  logic [WAYS-2:0]     setPlru, plruAfter;
  logic [WAY_W-1:0]    hitWay, victimWay, respWay;
  logic                anyHit, respHit, plruUpd;

  // Flush datapath signals
  logic                scanValid, scanDirty, lastEntry, advance;

  assign inResp = (state_q == RESP);

  // Set lookup. The victim prefers the lowest invalid way and only falls back
  // to the PLRU tree (as it stands before this request) when the set is full.
  always_comb begin
    setValid = valid_q[reqIdx_q];
    setDirty = dirty_q[reqIdx_q];
    setPlru  = plru_q[reqIdx_q];
    hitVec   = '0;
    for (int w = 0; w < WAYS; w++) begin
      hitVec[w] = setValid[w] && (tag_q[reqIdx_q][w] == reqTag_q);
    end
    anyHit    = |hitVec;
    hitWay    = lowestSet(hitVec);
    victimWay = (&setValid) ? plruVictim(setPlru) : lowestSet(~setValid);

    respHit = anyHit;
    respWay = anyHit ? hitWay : victimWay;
    unique case (reqMode_q)
      2'b10: begin
        respHit = setValid[reqWay_q];
        respWay = reqWay_q;
      end
      2'b11: respWay = victimWay;
      default: ;
    endcase

    plruUpd   = reqUpd_q && (respHit || (reqMode_q == 2'b11));
    plruAfter = plruUpd ? plruTouch(setPlru, respWay) : setPlru;
  end

  assign scanValid = valid_q[scanSet_q][scanWay_q];
  assign scanDirty = dirty_q[scanSet_q][scanWay_q];
  assign lastEntry = (scanSet_q == LAST_SET) && (scanWay_q == LAST_WAY);

  // Next-state logic. A simultaneous flush_start wins over req_valid.
  // Type 0 flushes a whole set per cycle; the other types walk entry by entry
  // and detour through FLUSH_WB for each valid and dirty line.
  always_comb begin
    state_d     = state_q;
    reqIdx_d    = reqIdx_q;
    reqTag_d    = reqTag_q;
    reqMode_d   = reqMode_q;
    reqWay_d    = reqWay_q;
    reqUpd_d    = reqUpd_q;
    flushType_d = flushType_q;
    scanSet_d   = scanSet_q;
    scanWay_d   = scanWay_q;
    done_d      = 1'b0;
    advance     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (flush_start) begin
          state_d     = FLUSH_SCAN;
          flushType_d = flush_type;
          scanSet_d   = '0;
          scanWay_d   = '0;
        end else if (req_valid) begin
          state_d   = RESP;
          reqIdx_d  = req_index;
          reqTag_d  = req_tag;
          reqMode_d = req_mode;
          reqWay_d  = req_way;
          reqUpd_d  = update_metadata;
        end
      end
      RESP: state_d = IDLE;
      FLUSH_SCAN: begin
        if (flushType_q == 2'b00) begin
          scanWay_d = '0;
          if (scanSet_q == LAST_SET) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            scanSet_d = scanSet_q + IDX_W'(1);
          end
        end else if (scanValid && scanDirty) begin
          state_d = FLUSH_WB;
        end else begin
          advance = 1'b1;
        end
      end
      FLUSH_WB: begin
        if (wb_ready) begin
          state_d = FLUSH_SCAN;
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (lastEntry) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (scanWay_q == LAST_WAY) begin
        scanWay_d = '0;
        scanSet_d = scanSet_q + IDX_W'(1);
      end else begin
        scanWay_d = scanWay_q + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      reqIdx_q    <= '0;
      reqTag_q    <= '0;
      reqMode_q   <= '0;
      reqWay_q    <= '0;
      reqUpd_q    <= 1'b0;
      flushType_q <= '0;
      scanSet_q   <= '0;
      scanWay_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      reqIdx_q    <= reqIdx_d;
      reqTag_q    <= reqTag_d;
      reqMode_q   <= reqMode_d;
      reqWay_q    <= reqWay_d;
      reqUpd_q    <= reqUpd_d;
      flushType_q <= flushType_d;
      scanSet_q   <= scanSet_d;
      scanWay_q   <= scanWay_d;
      done_q      <= done_d;
    end
  end

  // Array updates. Lookup updates commit on the edge that ends RESP, so the
  // following request already sees them. flushType_q[1] marks the
  // invalidating flush types (2 and 3). Flush never touches PLRU bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
        end
      end
    end else begin
      if (inResp) begin
        if ((reqMode_q == 2'b01) && anyHit) begin
          dirty_q[reqIdx_q][hitWay] <= 1'b1;
        end
        if (reqMode_q == 2'b11) begin
          tag_q[reqIdx_q][victimWay]   <= reqTag_q;
          valid_q[reqIdx_q][victimWay] <= 1'b1;
          dirty_q[reqIdx_q][victimWay] <= 1'b0;
        end
        plru_q[reqIdx_q] <= plruAfter;
      end
      if (state_q == FLUSH_SCAN) begin
        if (flushType_q == 2'b00) begin
          valid_q[scanSet_q] <= '0;
          dirty_q[scanSet_q] <= '0;
        end else if (flushType_q[1] && !(scanValid && scanDirty)) begin
          valid_q[scanSet_q][scanWay_q] <= 1'b0;
        end
      end
      if ((state_q == FLUSH_WB) && wb_ready) begin
        dirty_q[scanSet_q][scanWay_q] <= 1'b0;
        if (flushType_q[1]) begin
          valid_q[scanSet_q][scanWay_q] <= 1'b0;
        end
      end
    end
  end

  // Outputs are gated by state so they read as zero outside their phase,
  // including while rst is asserted.
  assign req_ready        = (state_q == IDLE) && !rst && !flush_start;
  assign resp_valid       = inResp;
  assign resp_hit         = inResp && respHit;
  assign resp_way         = inResp ? respWay : '0;
  assign resp_tag         = inResp ? tag_q[reqIdx_q][respWay] : '0;
  assign resp_dirty       = inResp && setDirty[respWay];
  assign resp_victim_way  = inResp ? victimWay : '0;
  assign resp_valid_array = inResp ? setValid : '0;
  assign resp_dirty_array = inResp ? setDirty : '0;
  assign resp_plru        = inResp ? plruAfter : '0;

  assign flush_busy = (state_q == FLUSH_SCAN) || (state_q == FLUSH_WB);
  assign flush_done = done_q;
  assign wb_valid   = (state_q == FLUSH_WB);
  assign wb_index   = wb_valid ? scanSet_q : '0;
  assign wb_way     = wb_valid ? scanWay_q : '0;
  assign wb_tag     = wb_valid ? tag_q[scanSet_q][scanWay_q] : '0;

endmodule

// File: tb/tb_dcache_tag_lookup.sv
module tb_dcache_tag_lookup;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default configuration: 64 sets, 4 ways, 18-bit tags
  logic        req_valid, req_ready, update_metadata;
  logic [5:0]  req_index;
  logic [17:0] req_tag;
  logic [1:0]  req_mode, req_way;
  logic        resp_valid, resp_hit, resp_dirty;
  logic [1:0]  resp_way, resp_victim_way;
  logic [17:0] resp_tag;
  logic [3:0]  resp_valid_array, resp_dirty_array;
  logic [2:0]  resp_plru;
  logic        flush_start, flush_busy, flush_done, wb_valid, wb_ready;
  logic [1:0]  flush_type, wb_way;
  logic [5:0]  wb_index;
  logic [17:0] wb_tag;

  // Second configuration: 16 sets, 8 ways
  logic        bReqValid, bReqReady, bUpd;
  logic [3:0]  bReqIndex;
  logic [17:0] bReqTag;
  logic [1:0]  bReqMode;
  logic [2:0]  bReqWay;
  logic        bRespValid, bRespHit, bRespDirty;
  logic [2:0]  bRespWay, bRespVictim;
  logic [17:0] bRespTag;
  logic [7:0]  bRespValidArr, bRespDirtyArr;
  logic [6:0]  bRespPlru;
  logic        bFlushStart, bFlushBusy, bFlushDone, bWbValid, bWbReady;
  logic [1:0]  bFlushType;
  logic [2:0]  bWbWay;
  logic [3:0]  bWbIndex;
  logic [17:0] bWbTag;

  dcache_tag_lookup dutA (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_tag(req_tag), .req_mode(req_mode), .req_way(req_way),
    .update_metadata(update_metadata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_tag(resp_tag), .resp_dirty(resp_dirty), .resp_victim_way(resp_victim_way),
    .resp_valid_array(resp_valid_array), .resp_dirty_array(resp_dirty_array),
    .resp_plru(resp_plru),
    .flush_start(flush_start), .flush_type(flush_type), .flush_busy(flush_busy),
    .flush_done(flush_done), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_index(wb_index), .wb_way(wb_way), .wb_tag(wb_tag)
  );

  dcache_tag_lookup #(.NUM_SETS(16), .WAYS(8), .TAG_SIZE(18)) dutB (
    .clk(clk), .rst(rst),
    .req_valid(bReqValid), .req_ready(bReqReady), .req_index(bReqIndex),
    .req_tag(bReqTag), .req_mode(bReqMode), .req_way(bReqWay),
    .update_metadata(bUpd),
    .resp_valid(bRespValid), .resp_hit(bRespHit), .resp_way(bRespWay),
    .resp_tag(bRespTag), .resp_dirty(bRespDirty), .resp_victim_way(bRespVictim),
    .resp_valid_array(bRespValidArr), .resp_dirty_array(bRespDirtyArr),
    .resp_plru(bRespPlru),
    .flush_start(bFlushStart), .flush_type(bFlushType), .flush_busy(bFlushBusy),
    .flush_done(bFlushDone), .wb_valid(bWbValid), .wb_ready(bWbReady),
    .wb_index(bWbIndex), .wb_way(bWbWay), .wb_tag(bWbTag)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [17:0] tag;
    logic [1:0]  mode;
    logic [1:0]  way;
    logic        upd;
    logic        eHit;
    logic [1:0]  eWay;
    logic [17:0] eTag;
    logic        eDirty;
    logic [1:0]  eVictim;
    logic [3:0]  eValid;
    logic [3:0]  eDirtyArr;
    logic [2:0]  ePlru;
  } vec_t;

  vec_t vecs[$];

  // Captured response of the last request on dutA
  logic        rHit, rDirty;
  logic [1:0]  rWay, rVictim;
  logic [17:0] rTag;
  logic [3:0]  rValidArr, rDirtyArr;
  logic [2:0]  rPlru;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [5:0] idx, input logic [17:0] tag, input logic [1:0] mode,
                        input logic [1:0] way, input logic upd, input logic eHit,
                        input logic [1:0] eWay, input logic [17:0] eTag, input logic eDirty,
                        input logic [1:0] eVictim, input logic [3:0] eValid,
                        input logic [3:0] eDirtyArr, input logic [2:0] ePlru);
    vec_t v;
    v.idx = idx; v.tag = tag; v.mode = mode; v.way = way; v.upd = upd;
    v.eHit = eHit; v.eWay = eWay; v.eTag = eTag; v.eDirty = eDirty; v.eVictim = eVictim;
    v.eValid = eValid; v.eDirtyArr = eDirtyArr; v.ePlru = ePlru;
    vecs.push_back(v);
  endtask

  // One request on dutA: present at a negedge, response sampled exactly one
  // cycle after acceptance.
  task automatic applyStimulus(input logic [5:0] idx, input logic [17:0] tag,
                               input logic [1:0] mode, input logic [1:0] way, input logic upd);
    @(negedge clk);
    req_valid = 1'b1; req_index = idx; req_tag = tag;
    req_mode = mode; req_way = way; update_metadata = upd;
    checkOutput("req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("resp_valid_latency", 32'(resp_valid), 32'd1);
    rHit = resp_hit; rWay = resp_way; rTag = resp_tag; rDirty = resp_dirty;
    rVictim = resp_victim_way; rValidArr = resp_valid_array;
    rDirtyArr = resp_dirty_array; rPlru = resp_plru;
  endtask

  task automatic applyStimulusB(input logic [3:0] idx, input logic [17:0] tag);
    @(negedge clk);
    bReqValid = 1'b1; bReqIndex = idx; bReqTag = tag; bReqMode = 2'b11; bReqWay = '0; bUpd = 1'b1;
    @(negedge clk);
    bReqValid = 1'b0;
    checkOutput("b_resp_valid", 32'(bRespValid), 32'd1);
  endtask

  initial begin
    int  offers, dones, hold;
    bit  finished, sawWb, sawDone, prevWb;
    logic [7:0] wayMask;
    int  seq[8];

    req_valid = 0; req_index = '0; req_tag = '0; req_mode = '0; req_way = '0;
    update_metadata = 0; flush_start = 0; flush_type = '0; wb_ready = 0;
    bReqValid = 0; bReqIndex = '0; bReqTag = '0; bReqMode = '0; bReqWay = '0;
    bUpd = 0; bFlushStart = 0; bFlushType = '0; bWbReady = 0;

    // Reset state
    #2;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_flush_busy", 32'(flush_busy), 32'd0);
    checkOutput("rst_flush_done", 32'(flush_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("req_ready_after_rst", 32'(req_ready), 32'd1);

    // idx tag mode way upd | hit way tag dirty victim valid dirtyArr plru
    addVec(6'd5, 18'h10, 2'b11, 2'd0, 1'b1, 1'b0, 2'd0, 18'h0,  1'b0, 2'd0, 4'b0000, 4'b0000, 3'b011);
    addVec(6'd5, 18'h11, 2'b11, 2'd0, 1'b1, 1'b0, 2'd1, 18'h0,  1'b0, 2'd1, 4'b0001, 4'b0000, 3'b001);
    addVec(6'd5, 18'h12, 2'b11, 2'd0, 1'b1, 1'b0, 2'd2, 18'h0,  1'b0, 2'd2, 4'b0011, 4'b0000, 3'b100);
    addVec(6'd5, 18'h13, 2'b11, 2'd0, 1'b1, 1'b0, 2'd3, 18'h0,  1'b0, 2'd3, 4'b0111, 4'b0000, 3'b000);
    addVec(6'd5, 18'h12, 2'b00, 2'd0, 1'b1, 1'b1, 2'd2, 18'h12, 1'b0, 2'd0, 4'b1111, 4'b0000, 3'b100);
    addVec(6'd5, 18'h99, 2'b00, 2'd0, 1'b1, 1'b0, 2'd0, 18'h10, 1'b0, 2'd0, 4'b1111, 4'b0000, 3'b100);
    addVec(6'd5, 18'h11, 2'b01, 2'd0, 1'b1, 1'b1, 2'd1, 18'h11, 1'b0, 2'd0, 4'b1111, 4'b0000, 3'b101);
    addVec(6'd5, 18'h3FFFF, 2'b10, 2'd1, 1'b0, 1'b1, 2'd1, 18'h11, 1'b1, 2'd3, 4'b1111, 4'b0010, 3'b101);
    addVec(6'd6, 18'h11, 2'b00, 2'd0, 1'b1, 1'b0, 2'd0, 18'h0,  1'b0, 2'd0, 4'b0000, 4'b0000, 3'b000);
    addVec(6'd5, 18'h55, 2'b01, 2'd0, 1'b1, 1'b0, 2'd3, 18'h13, 1'b0, 2'd3, 4'b1111, 4'b0010, 3'b101);
    addVec(6'd6, 18'h0,  2'b10, 2'd2, 1'b1, 1'b0, 2'd2, 18'h0,  1'b0, 2'd0, 4'b0000, 4'b0000, 3'b000);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].idx, vecs[i].tag, vecs[i].mode, vecs[i].way, vecs[i].upd);
      checkOutput($sformatf("v%0d_hit", i), 32'(rHit), 32'(vecs[i].eHit));
      checkOutput($sformatf("v%0d_way", i), 32'(rWay), 32'(vecs[i].eWay));
      checkOutput($sformatf("v%0d_tag", i), 32'(rTag), 32'(vecs[i].eTag));
      checkOutput($sformatf("v%0d_dirty", i), 32'(rDirty), 32'(vecs[i].eDirty));
      checkOutput($sformatf("v%0d_victim", i), 32'(rVictim), 32'(vecs[i].eVictim));
      checkOutput($sformatf("v%0d_valid_arr", i), 32'(rValidArr), 32'(vecs[i].eValid));
      checkOutput($sformatf("v%0d_dirty_arr", i), 32'(rDirtyArr), 32'(vecs[i].eDirtyArr));
      checkOutput($sformatf("v%0d_plru", i), 32'(rPlru), 32'(vecs[i].ePlru));
    end

    // flush_start and req_valid together: flush wins, request dropped
    @(negedge clk);
    flush_start = 1'b1; flush_type = 2'd1;
    req_valid = 1'b1; req_index = 6'd5; req_tag = 18'h12; req_mode = 2'b00;
    #1;
    checkOutput("req_ready_vs_flush", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush_start = 1'b0; req_valid = 1'b0;
    checkOutput("req_not_accepted", 32'(resp_valid), 32'd0);
    checkOutput("flush_busy_next", 32'(flush_busy), 32'd1);

    // Type-1 flush: the single dirty line is offered and held for 3 cycles
    offers = 0; dones = 0; hold = 0; finished = 0; prevWb = 0;
    for (int c = 0; c < 600 && !finished; c++) begin
      @(negedge clk);
      wb_ready = 1'b0;
      if (flush_done) begin
        dones++;
        finished = 1;
      end
      if (wb_valid) begin
        if (!prevWb) offers++;
        checkOutput("wb_index", 32'(wb_index), 32'd5);
        checkOutput("wb_way", 32'(wb_way), 32'd1);
        checkOutput("wb_tag", 32'(wb_tag), 32'h11);
        hold++;
        if (hold == 4) begin
          wb_ready = 1'b1;
          hold = 0;
        end
      end
      prevWb = wb_valid;
    end
    checkOutput("flush1_completed", 32'(finished), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (flush_done) dones++;
    end
    checkOutput("flush1_offers", 32'(offers), 32'd1);
    checkOutput("flush1_done_pulses", 32'(dones), 32'd1);
    checkOutput("flush1_busy_after", 32'(flush_busy), 32'd0);
    applyStimulus(6'd5, 18'h0, 2'b10, 2'd1, 1'b0);
    checkOutput("flush1_valid_kept", 32'(rHit), 32'd1);
    checkOutput("flush1_dirty_cleared", 32'(rDirty), 32'd0);
    checkOutput("flush1_dirty_arr", 32'(rDirtyArr), 32'd0);
    checkOutput("flush1_plru_kept", 32'(rPlru), 32'b101);

    // Reset during FLUSH_WB
    applyStimulus(6'd5, 18'h12, 2'b01, 2'd0, 1'b0);
    checkOutput("wr_hit_way2", 32'(rWay), 32'd2);
    @(negedge clk);
    flush_start = 1'b1; flush_type = 2'd2;
    @(negedge clk);
    flush_start = 1'b0;
    sawWb = 0;
    for (int c = 0; c < 400 && !sawWb; c++) begin
      @(negedge clk);
      if (wb_valid) sawWb = 1;
    end
    checkOutput("flush2_wb_seen", 32'(sawWb), 32'd1);
    checkOutput("flush2_wb_way", 32'(wb_way), 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_mid_busy", 32'(flush_busy), 32'd0);
    checkOutput("rst_mid_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_req_ready_rel", 32'(req_ready), 32'd1);
    sawWb = 0; sawDone = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (wb_valid) sawWb = 1;
      if (flush_done) sawDone = 1;
    end
    checkOutput("rst_no_wb_after", 32'(sawWb), 32'd0);
    checkOutput("rst_no_done_after", 32'(sawDone), 32'd0);
    applyStimulus(6'd5, 18'h0, 2'b10, 2'd2, 1'b0);
    checkOutput("rst_arr_hit", 32'(rHit), 32'd0);
    checkOutput("rst_arr_tag", 32'(rTag), 32'd0);
    checkOutput("rst_arr_valid", 32'(rValidArr), 32'd0);
    checkOutput("rst_arr_dirty", 32'(rDirtyArr), 32'd0);
    checkOutput("rst_arr_plru", 32'(rPlru), 32'd0);

    // Type-0 flush invalidates without writebacks
    applyStimulus(6'd3, 18'h7, 2'b11, 2'd0, 1'b1);
    applyStimulus(6'd3, 18'h7, 2'b01, 2'd0, 1'b1);
    checkOutput("t0_pre_hit", 32'(rHit), 32'd1);
    @(negedge clk);
    flush_start = 1'b1; flush_type = 2'd0;
    @(negedge clk);
    flush_start = 1'b0;
    sawWb = 0; sawDone = 0;
    for (int c = 0; c < 200 && !sawDone; c++) begin
      @(negedge clk);
      if (wb_valid) sawWb = 1;
      if (flush_done) sawDone = 1;
    end
    checkOutput("t0_done", 32'(sawDone), 32'd1);
    checkOutput("t0_no_wb", 32'(sawWb), 32'd0);
    applyStimulus(6'd3, 18'h7, 2'b00, 2'd0, 1'b0);
    checkOutput("t0_miss", 32'(rHit), 32'd0);
    checkOutput("t0_valid_arr", 32'(rValidArr), 32'd0);

    // 8-way configuration: sequential fill, then PLRU replacement order
    for (int i = 0; i < 8; i++) begin
      applyStimulusB(4'd2, 18'h100 + 18'(i));
      checkOutput($sformatf("b_fill%0d_way", i), 32'(bRespWay), 32'(i));
    end
    seq = '{0, 4, 2, 6, 1, 5, 3, 7};
    wayMask = '0;
    for (int i = 0; i < 8; i++) begin
      applyStimulusB(4'd2, 18'h200 + 18'(i));
      checkOutput($sformatf("b_repl%0d_way", i), 32'(bRespWay), 32'(seq[i]));
      checkOutput($sformatf("b_repl%0d_evicted", i), 32'(bRespTag), 32'h100 + 32'(seq[i]));
      wayMask[bRespWay] = 1'b1;
    end
    checkOutput("b_all_ways_cycled", 32'(wayMask), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_tag_lookup.md
DCACHE_TAG_LOOKUP -- requirements
Module: dcache_tag_lookup

Interface
REQ-001 SHALL have parameter NUM_SETS, default 64, number of sets (power of 2, >=2).
REQ-002 SHALL have parameter WAYS, default 4, associativity (power of 2, >=2).
REQ-003 SHALL have parameter TAG_SIZE, default 18, tag width in bits.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-005 Request and response ports SHALL be:
- req_valid  in  1  request strobe
- req_ready  out  1  request accepted when high with req_valid
- req_index  in  clog2(NUM_SETS)  set index
- req_tag  in  TAG_SIZE  lookup or fill tag
- req_mode  in  2  00 tagcheck read, 01 tagcheck write, 10 no-tagcheck read, 11 fill
- req_way  in  clog2(WAYS)  way for mode 10
- update_metadata  in  1  PLRU update enable
- resp_valid  out  1  one-cycle response strobe
- resp_hit  out  1  tag match on a valid way
- resp_way  out  clog2(WAYS)  hit, selected or filled way
- resp_tag  out  TAG_SIZE  stored tag of resp_way
- resp_dirty  out  1  dirty bit of resp_way before update
- resp_victim_way  out  clog2(WAYS)  replacement candidate
- resp_valid_array  out  WAYS  valid bits of set before update
- resp_dirty_array  out  WAYS  dirty bits of set before update
- resp_plru  out  WAYS-1  PLRU bits of set after update
REQ-006 Flush and writeback ports SHALL be:
- flush_start  in  1  start flush
- flush_type  in  2  flush type
- flush_busy  out  1  flush in progress
- flush_done  out  1  one-cycle flush completion pulse
- wb_valid  out  1  writeback offer
- wb_ready  in  1  writeback accepted
- wb_index  out  clog2(NUM_SETS)  writeback set
- wb_way  out  clog2(WAYS)  writeback way
- wb_tag  out  TAG_SIZE  writeback tag

Function
REQ-007 Storage SHALL be per set: WAYS tags, WAYS valid bits, WAYS dirty bits and WAYS-1 tree-PLRU bits, all in registers.
REQ-008 FSM states SHALL be IDLE, RESP, FLUSH_SCAN and FLUSH_WB.
REQ-009 req_ready SHALL be high only in IDLE; flush_start SHALL take priority over req_valid in the same cycle, and that request SHALL NOT be accepted.
REQ-010 An accepted request SHALL produce resp_valid exactly one cycle later (state RESP) and then return to IDLE, giving one request per two cycles.
REQ-011 Hit SHALL mean valid[w] && tag[w]==req_tag; multiple hits SHALL NOT occur, and the lowest matching way is reported.
REQ-012 Victim way SHALL be the lowest-index invalid way; when all ways are valid it SHALL be the way indicated by the PLRU tree.
REQ-013 Mode 00 SHALL leave tag, valid and dirty unchanged.
REQ-014 Mode 01 on a hit SHALL set dirty[resp_way]; a miss SHALL change nothing and SHALL report resp_way = victim.
REQ-015 Mode 10 SHALL use req_way, SHALL report resp_hit = valid[req_way], and SHALL ignore req_tag.
REQ-016 Mode 11 SHALL write req_tag into the victim way with valid=1 and dirty=0, SHALL report resp_way = victim, and resp_dirty/resp_tag SHALL show the evicted entry.
REQ-017 When update_metadata=1 and (hit or mode 11), the PLRU bits along the path SHALL be set to point away from resp_way; otherwise PLRU SHALL be unchanged.
REQ-018 Array updates SHALL commit on the clock edge ending RESP; the next request therefore sees the updated set.
REQ-019 Flush SHALL be started by flush_start in IDLE; flush_busy SHALL be high from the next cycle until flush_done.
REQ-020 Flush type 0 SHALL clear all valid and dirty bits at one set per cycle, with no writeback.
REQ-021 Flush type 1 SHALL offer each valid and dirty entry on wb_*.
REQ-022 Flush type 2 (and type 3, treated as type 2) SHALL behave as type 1 and SHALL also clear the valid bit of every entry.
REQ-023 Flush scan order SHALL be set 0..NUM_SETS-1 and, within a set, way 0..WAYS-1; the scan SHALL take one cycle per entry with no writeback.
REQ-024 wb_valid SHALL stay high, with stable wb_index, wb_way and wb_tag, until wb_ready; the entry's dirty bit SHALL be cleared on the handshake cycle.
REQ-025 flush_done SHALL pulse the cycle after the last entry completes, and the FSM SHALL then return to IDLE; PLRU bits SHALL NOT be changed by flush.
REQ-026 flush_start while busy SHALL be ignored.

Reset
REQ-027 On rst, asynchronously: state=IDLE; all valid, dirty and PLRU bits 0; tags 0; req_ready=0 while rst is asserted, then 1.
REQ-028 On rst, asynchronously, all resp_*, wb_valid, flush_busy and flush_done SHALL be 0.
REQ-029 rst mid-flush or mid-response SHALL abort the operation with no further wb_valid, resp_valid or flush_done.

Verification
REQ-030 After reset, fill set 5 with tags 0x10..0x13 (update_metadata=1) -> resp_way 0,1,2,3 in order, resp_valid_array 0000,0001,0011,0111.
REQ-031 Read tag 0x12 in set 5 -> resp_hit=1, resp_way=2, and latency is exactly 1 cycle; read tag 0x99 -> resp_hit=0, resp_victim_way equals the PLRU way.
REQ-032 Write hit on tag 0x11, then a type-1 flush with wb_ready held low 3 cycles -> one wb offer (index 5, way 1, tag 0x11) held stable, dirty cleared, valid kept, flush_done once.
REQ-033 Assert flush_start and req_valid in the same cycle -> request not accepted, flush_busy=1 next cycle.
REQ-034 Assert rst during FLUSH_WB -> wb_valid=0 immediately, all arrays cleared, req_ready=1 after reset release.
REQ-035 Repeat the tests with WAYS=8 and NUM_SETS=16 -> the PLRU victim cycles through all 8 ways under a sequential fill-after-full pattern.
